// File: rtl/gb_regbank.sv
// Host-bus register bank: NCSR read/write CSRs, a status word, a saturating
// error counter and a small RAM window, all behind a fixed-latency read pipeline.
module gb_regbank #(
    parameter int              AW       = 12,
    parameter int              DW       = 32,
    parameter int              NCSR     = 4,
    parameter logic [DW-1:0]   CSR_INIT = '0,
    parameter int              RAM_AW   = 6,
    parameter int              RAM_DW   = 8,
    parameter int              RAM_BASE = 'h100,
    parameter int              RD_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        gb_addr,
    input  logic [DW-1:0]        gb_dout,
    input  logic                 gb_we,
    input  logic                 gb_re,
    output logic [DW-1:0]        gb_din,
    output logic                 gb_rvalid,
    output logic                 gb_err,
    output logic [NCSR*DW-1:0]   csr_q,
    output logic [NCSR-1:0]      csr_wstb,
    input  logic [DW-1:0]        status_in
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("gb_regbank: RD_LAT must be 1..4");
    end
    if (NCSR < 1 || NCSR > 16 || RAM_DW < 1 || RAM_DW > DW || DW < 16 || AW <= RAM_AW) begin : g_bad_size
        $error("gb_regbank: illegal width/count parameters");
    end
    if ((RAM_BASE % (2 ** RAM_AW)) != 0 || RAM_BASE <= NCSR + 1 ||
        RAM_BASE + (2 ** RAM_AW) > (2 ** AW)) begin : g_bad_map
        $error("gb_regbank: RAM window misaligned, overlapping or out of range");
    end

    localparam logic [AW-1:0] CSR_END   = AW'(NCSR);
    localparam logic [AW-1:0] STAT_ADDR = AW'(NCSR);
    localparam logic [AW-1:0] CNT_ADDR  = AW'(NCSR + 1);
    localparam logic [AW-1:0] RAM_ADDR  = AW'(RAM_BASE);

    logic [NCSR-1:0][DW-1:0] csr;
    logic [RAM_DW-1:0]       ram [2**RAM_AW];
    logic [15:0]             err_cnt;
    logic                    wr_err;

    logic csr_hit, stat_hit, cnt_hit, ram_hit, unmapped;
    assign csr_hit  = gb_addr < CSR_END;
    assign stat_hit = gb_addr == STAT_ADDR;
    assign cnt_hit  = gb_addr == CNT_ADDR;
    assign ram_hit  = gb_addr[AW-1:RAM_AW] == RAM_ADDR[AW-1:RAM_AW];
    assign unmapped = !(csr_hit || stat_hit || cnt_hit || ram_hit);

    assign csr_q = csr;

    // CSR writes, per-CSR strobes and write-side error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr      <= {NCSR{CSR_INIT}};
            csr_wstb <= '0;
            wr_err   <= 1'b0;
        end else begin
            wr_err <= gb_we && (stat_hit || unmapped);
            for (int i = 0; i < NCSR; i++) begin
                csr_wstb[i] <= gb_we && (gb_addr == AW'(i));
                if (gb_we && (gb_addr == AW'(i))) begin
                    csr[i] <= gb_dout;
                end
            end
        end
    end

    // RAM contents survive reset; writes are only blocked while rst is high
    always_ff @(posedge clk) begin
        if (!rst && gb_we && ram_hit) begin
            ram[gb_addr[RAM_AW-1:0]] <= gb_dout[RAM_DW-1:0];
        end
    end

    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_bad;
    assign rd_req = gb_re && !gb_we;

    always_comb begin
        rd_data = '0;
        rd_bad  = 1'b0;
        for (int i = 0; i < NCSR; i++) begin
            if (gb_addr == AW'(i)) rd_data = csr[i];
        end
        if (stat_hit)      rd_data = status_in;
        else if (cnt_hit)  rd_data = DW'(err_cnt);
        else if (ram_hit)  rd_data = DW'(ram[gb_addr[RAM_AW-1:0]]);
        else if (unmapped) rd_bad  = 1'b1;
    end

    // Read pipeline: stage 0 captures the decoded read, last stage drives the bus
    logic [RD_LAT-1:0]         v_sr, e_sr;
    logic [RD_LAT-1:0][DW-1:0] d_sr;
    logic [RD_LAT:0]           v_cat, e_cat;
    logic [RD_LAT:0][DW-1:0]   d_cat;

    assign v_cat = {v_sr, rd_req};
    assign e_cat = {e_sr, rd_req && rd_bad};
    assign d_cat = {d_sr, rd_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sr <= '0;
            e_sr <= '0;
            d_sr <= '0;
        end else begin
            v_sr <= v_cat[RD_LAT-1:0];
            e_sr <= e_cat[RD_LAT-1:0];
            d_sr <= d_cat[RD_LAT-1:0];
            // output stage holds the last returned word between reads
            if (!v_cat[RD_LAT-1]) d_sr[RD_LAT-1] <= d_sr[RD_LAT-1];
        end
    end

    assign gb_rvalid = v_sr[RD_LAT-1];
    assign gb_din    = d_sr[RD_LAT-1];
    assign gb_err    = wr_err || (v_sr[RD_LAT-1] && e_sr[RD_LAT-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (gb_we && cnt_hit) begin
            err_cnt <= '0;
        end else if (gb_err && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: doc/gb_regbank.md
GB_REGBANK -- requirements
Module: gb_regbank

Interface
REQ-001 SHALL have parameter AW, default 12, bus address width.
REQ-002 SHALL have parameter DW, default 32, bus data width.
REQ-003 SHALL have parameter NCSR, default 4, number of read/write CSRs (1..16).
REQ-004 SHALL have parameter CSR_INIT, default 0, reset value of every CSR (DW bits).
REQ-005 SHALL have parameter RAM_AW, default 6, RAM address width (depth 2**RAM_AW).
REQ-006 SHALL have parameter RAM_DW, default 8, RAM word width (1..DW).
REQ-007 SHALL have parameter RAM_BASE, default 'h100, RAM base address, aligned to 2**RAM_AW.
REQ-008 SHALL have parameter RD_LAT, default 2, read latency in cycles (1..4).
REQ-009 clk  input  1  single clock for all logic.
REQ-010 rst  input  1  reset, asynchronous, active-high.
REQ-011 gb_addr  input  AW  word address.
REQ-012 gb_dout  input  DW  host write data.
REQ-013 gb_we  input  1  write strobe, one transfer per cycle high.
REQ-014 gb_re  input  1  read strobe, one transfer per cycle high.
REQ-015 gb_din  output  DW  read data to host.
REQ-016 gb_rvalid  output  1  one-cycle pulse marking gb_din valid.
REQ-017 gb_err  output  1  one-cycle pulse on illegal access.
REQ-018 csr_q  output  NCSR*DW  CSR contents, CSR i at bits [i*DW +: DW].
REQ-019 csr_wstb  output  NCSR  one-cycle pulse per CSR written.
REQ-020 status_in  input  DW  read-only status word, sampled at read.

Function
REQ-021 Map SHALL be: CSR i at address i; status_in at NCSR; error counter at NCSR+1; RAM at RAM_BASE..RAM_BASE+2**RAM_AW-1; all else unmapped.
REQ-022 Parameter set with RAM range overlapping 0..NCSR+1, RD_LAT outside 1..4, or RAM_BASE misaligned SHALL fail elaboration.
REQ-023 gb_we to CSR i SHALL update CSR i on that clk edge and pulse csr_wstb[i] high for the following cycle.
REQ-024 gb_we to RAM SHALL store gb_dout[RAM_DW-1:0] at gb_addr[RAM_AW-1:0] on that edge.
REQ-025 gb_we to error-counter address SHALL clear the counter to 0 (not an error).
REQ-026 gb_we to status address or unmapped address SHALL change no state and pulse gb_err.
REQ-027 gb_re with gb_we low SHALL produce gb_rvalid exactly RD_LAT cycles after the strobe cycle, with gb_din valid on that cycle.
REQ-028 Reads SHALL be fully pipelined: back-to-back gb_re every cycle yields one gb_rvalid per read, in order, no bubbles.
REQ-029 Read data SHALL be zero-extended to DW (RAM words, 16-bit counter).
REQ-030 Unmapped read SHALL return 0, assert gb_rvalid, and pulse gb_err coincident with gb_rvalid.
REQ-031 gb_din SHALL hold the last returned value while gb_rvalid is low.
REQ-032 gb_we and gb_re both high SHALL perform the write only; no gb_rvalid for that cycle.
REQ-033 Read issued the cycle after a write to the same address SHALL return the new value.
REQ-034 Error counter SHALL be 16 bits, increment on every gb_err pulse, saturate at 'hFFFF; clear-write SHALL win over a coincident increment.
REQ-035 Write-side gb_err SHALL pulse the cycle after the offending strobe.

Reset
REQ-036 rst high SHALL immediately force: all CSRs = CSR_INIT, csr_wstb = 0, gb_rvalid = 0, gb_err = 0, gb_din = 0, error counter = 0, read pipeline empty.
REQ-037 Reads in flight when rst asserts SHALL be discarded; no gb_rvalid after rst deasserts for them.
REQ-038 RAM contents SHALL NOT be reset.
REQ-039 Strobes SHALL be ignored while rst is high.

Verification (defaults, RD_LAT=2)
REQ-040 Write 'hDEADBEEF to addr 2, read addr 2 next cycle -> csr_wstb=4'b0100 one cycle; gb_rvalid 2 cycles after read with gb_din='hDEADBEEF; csr_q[95:64]='hDEADBEEF.
REQ-041 Write 'h123456A5 to addr 'h13F, read 'h13F -> gb_din='h000000A5; read 'h100..'h103 on 4 consecutive cycles -> 4 consecutive gb_rvalid pulses, in order.
REQ-042 Read 'h200, write 'h004 (status) -> each produces one gb_err; read addr 5 -> gb_din='h00000002; write addr 5 then read addr 5 -> gb_din=0.
REQ-043 gb_we and gb_re high together at addr 1 with 'h55 -> CSR1='h55, no gb_rvalid.
REQ-044 Issue reads at addr 0 on 2 consecutive cycles, assert rst the next cycle -> outputs zero immediately, no gb_rvalid after release, CSR_INIT restored.
REQ-045 'h10001 unmapped reads -> counter reads 'hFFFF (saturated).
